// File: rtl/sysbus_pkg.sv
// Shared system-bus definitions: arbiter state codes, master select
// encodings and the default hold limit.
package sysbus_pkg;

    // State codes double as the master mux select driven on SELM
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        OWN1 = 2'b01,
        OWN2 = 2'b10
    } arb_state_t;

    localparam logic [1:0] SEL_NONE = 2'b00;
    localparam logic [1:0] SEL_M1   = 2'b01;
    localparam logic [1:0] SEL_M2   = 2'b10;

    localparam int HOLD_MAX_DEF = 16;

endpackage

// File: rtl/arb_hold_timer.sv
// Saturating count of cycles the bus owner has kept the other master
// waiting; expired flags the limit combinationally.
module arb_hold_timer
    import sysbus_pkg::*;
#(
    parameter int HOLD_MAX = HOLD_MAX_DEF
) (
    input  logic CLK,
    input  logic RST,
    input  logic en,
    input  logic clr,
    output logic expired
);

    localparam int CNT_W = (HOLD_MAX > 0) ? $clog2(HOLD_MAX + 1) : 1;
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(HOLD_MAX);

    logic [CNT_W-1:0] cnt;

    // With no limit LIMIT is zero, so the count never leaves zero
    assign expired = (HOLD_MAX != 0) && (cnt == LIMIT);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && (cnt != LIMIT)) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// Two-master round-robin bus arbiter with bounded hold time and
// handover only on slave-ready cycles.
module bus_arbiter
    import sysbus_pkg::*;
#(
    parameter int HOLD_MAX = HOLD_MAX_DEF
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       REQ_1,
    input  logic       REQ_2,
    input  logic       READY,
    output logic       GNT_1,
    output logic       GNT_2,
    output logic [1:0] SELM,
    output logic       BUSY
);

    arb_state_t state;
    arb_state_t nxt;
    logic       last_2;
    logic       r1;
    logic       r2;
    logic       rdy;
    logic       other_req;
    logic       expired;

    // Unknown inputs never trigger a transition
    assign r1  = (REQ_1 === 1'b1);
    assign r2  = (REQ_2 === 1'b1);
    assign rdy = (READY === 1'b1);

    assign other_req = (state == OWN1) ? r2 :
                       (state == OWN2) ? r1 : 1'b0;

    arb_hold_timer #(
        .HOLD_MAX(HOLD_MAX)
    ) u_hold (
        .CLK    (CLK),
        .RST    (RST),
        .en     (other_req),
        .clr    ((nxt != state) || !other_req),
        .expired(expired)
    );

    always_comb begin
        nxt = state;
        unique case (state)
            IDLE: begin
                if (r1 && r2)
                    nxt = last_2 ? OWN1 : OWN2;
                else if (r1)
                    nxt = OWN1;
                else if (r2)
                    nxt = OWN2;
            end
            OWN1: begin
                if (rdy && (!r1 || (expired && r2)))
                    nxt = r2 ? OWN2 : IDLE;
            end
            OWN2: begin
                if (rdy && (!r2 || (expired && r1)))
                    nxt = r1 ? OWN1 : IDLE;
            end
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state  <= IDLE;
            last_2 <= 1'b1;
            GNT_1  <= 1'b0;
            GNT_2  <= 1'b0;
            SELM   <= SEL_NONE;
            BUSY   <= 1'b0;
        end else begin
            state <= nxt;
            if (nxt != state && nxt == OWN1)
                last_2 <= 1'b0;
            else if (nxt != state && nxt == OWN2)
                last_2 <= 1'b1;
            GNT_1 <= (nxt == OWN1);
            GNT_2 <= (nxt == OWN2);
            SELM  <= nxt;
            BUSY  <= (nxt != IDLE);
        end
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// Scoreboard bench: three arbiters (hold 4, unlimited, 16) share one
// stimulus stream and are checked against an ownership model.
module tb_bus_arbiter;

    logic       CLK;
    logic       RST;
    logic       REQ_1;
    logic       REQ_2;
    logic       READY;
    logic       gnt1 [3];
    logic       gnt2 [3];
    logic [1:0] selm [3];
    logic       busy [3];

    localparam int HOLDS [3] = '{4, 0, 16};

    int checks = 0;
    int passed = 0;

    // Reference model: current owner (0 none), cycles waited, last owner
    int own    [3];
    int waited [3];
    int last   [3];
    int exp_q  [3][$];

    bus_arbiter #(.HOLD_MAX(4)) u_h4 (
        .CLK(CLK), .RST(RST), .REQ_1(REQ_1), .REQ_2(REQ_2), .READY(READY),
        .GNT_1(gnt1[0]), .GNT_2(gnt2[0]), .SELM(selm[0]), .BUSY(busy[0])
    );

    bus_arbiter #(.HOLD_MAX(0)) u_h0 (
        .CLK(CLK), .RST(RST), .REQ_1(REQ_1), .REQ_2(REQ_2), .READY(READY),
        .GNT_1(gnt1[1]), .GNT_2(gnt2[1]), .SELM(selm[1]), .BUSY(busy[1])
    );

    bus_arbiter #(.HOLD_MAX(16)) u_h16 (
        .CLK(CLK), .RST(RST), .REQ_1(REQ_1), .REQ_2(REQ_2), .READY(READY),
        .GNT_1(gnt1[2]), .GNT_2(gnt2[2]), .SELM(selm[2]), .BUSY(busy[2])
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act == exp)
            passed++;
        else
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    function automatic int pack_out(input int i);
        return {27'd0, gnt1[i], gnt2[i], selm[i], busy[i]};
    endfunction

    function automatic int pack_exp(input int n);
        int e;
        e = 0;
        if (n == 1) e = e | 16;
        if (n == 2) e = e | 8;
        e = e | (n << 1);
        if (n != 0) e = e | 1;
        return e;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            own[i]    = 0;
            waited[i] = 0;
            last[i]   = 2;
        end
    endtask

    // Apply inputs right after a falling edge, predict, wait one cycle
    task automatic step(input bit a, input bit b, input bit rd);
        REQ_1 = a;
        REQ_2 = b;
        READY = rd;
        for (int i = 0; i < 3; i++) begin
            int o;
            int n;
            bit ro;
            bit ry;
            o  = own[i];
            ro = 1'b0;
            ry = 1'b0;
            if (o == 0) begin
                if (a && b)  n = (last[i] == 1) ? 2 : 1;
                else if (a)  n = 1;
                else if (b)  n = 2;
                else         n = 0;
            end else begin
                ro = (o == 1) ? a : b;
                ry = (o == 1) ? b : a;
                n  = o;
                if (rd && (!ro || (HOLDS[i] > 0 && waited[i] >= HOLDS[i] && ry)))
                    n = ry ? 3 - o : 0;
            end
            if (o == 0 || n != o || !ry)
                waited[i] = 0;
            else if (waited[i] < HOLDS[i])
                waited[i] = waited[i] + 1;
            if (n != 0 && n != o)
                last[i] = n;
            own[i] = n;
            exp_q[i].push_back(n);
        end
        @(negedge CLK);
    endtask

    // Reset pulse mid-cycle: outputs must clear before any clock edge
    task automatic do_reset();
        #2 RST = 1'b1;
        #1;
        for (int i = 0; i < 3; i++)
            check($sformatf("async_reset[%0d]", i), pack_out(i), 0);
        @(negedge CLK);
        RST = 1'b0;
        model_reset();
    endtask

    // Monitor: pop one prediction per edge and check invariants
    initial begin
        forever begin
            @(posedge CLK);
            #1;
            if (!RST) begin
                check("input_x", int'($isunknown({REQ_1, REQ_2, READY})), 0);
                for (int i = 0; i < 3; i++) begin
                    if (exp_q[i].size() == 0) begin
                        check($sformatf("sb_underflow[%0d]", i), 1, 0);
                    end else begin
                        int n;
                        n = exp_q[i].pop_front();
                        check($sformatf("sb_out[%0d]", i), pack_out(i), pack_exp(n));
                    end
                    check($sformatf("onehot[%0d]", i), int'(gnt1[i] & gnt2[i]), 0);
                    check($sformatf("selm11[%0d]", i), int'(selm[i] == 2'b11), 0);
                    check($sformatf("busy[%0d]", i), int'(busy[i]), int'(|selm[i]));
                end
            end
        end
    end

    initial begin
        int first_g2;
        int g2_seen;
        bit a;
        bit b;

        RST   = 1'b1;
        REQ_1 = 1'b0;
        REQ_2 = 1'b0;
        READY = 1'b0;
        model_reset();
        repeat (2) @(negedge CLK);
        for (int i = 0; i < 3; i++)
            check($sformatf("reset_state[%0d]", i), pack_out(i), 0);
        RST = 1'b0;

        // Reset mid-grant, then first tie goes to master 1
        step(1, 0, 1);
        check("solo_grant_g1", int'(gnt1[0]), 1);
        check("solo_grant_selm", int'(selm[0]), 1);
        step(1, 0, 1);
        do_reset();
        step(1, 1, 1);
        check("tie_after_reset", int'(gnt1[0]), 1);
        step(0, 0, 1);
        check("release_idle", int'(busy[0]), 0);

        // Solo request and release to idle
        step(1, 0, 1);
        step(1, 0, 1);
        step(0, 0, 1);
        check("solo_release", int'(selm[2]), 0);

        // Tie from reset and round-robin handover
        do_reset();
        step(1, 1, 1);
        step(0, 1, 1);
        check("handover_no_gap", int'(gnt2[1]), 1);
        step(0, 0, 1);
        step(1, 1, 1);
        check("rr_back_to_1", int'(gnt1[1]), 1);
        step(0, 0, 1);

        // READY stall on release
        step(1, 0, 1);
        repeat (3) begin
            step(0, 0, 0);
            check("stall_hold", int'(gnt1[0]), 1);
        end
        step(0, 0, 1);
        check("stall_release", int'(busy[0]), 0);

        // Hold limit of 4 on u_h4
        step(1, 0, 1);
        step(1, 0, 1);
        first_g2 = 0;
        for (int k = 1; k <= 10; k++) begin
            step(1, 1, 1);
            if (first_g2 == 0 && gnt2[0]) begin
                first_g2 = k;
                check("forced_g1_drop", int'(gnt1[0]), 0);
            end
        end
        check("hold_latency", first_g2, 5);
        step(0, 0, 1);
        step(0, 0, 1);

        // Unlimited hold on u_h0
        do_reset();
        step(1, 0, 1);
        g2_seen = 0;
        repeat (100) begin
            step(1, 1, 1);
            if (gnt2[1]) g2_seen++;
        end
        check("nolimit_no_g2", g2_seen, 0);
        step(0, 1, 1);
        check("nolimit_release", int'(gnt2[1]), 1);
        step(0, 0, 1);

        // Randomised traffic with occasional resets
        a = 1'b0;
        b = 1'b0;
        for (int k = 0; k < 1500; k++) begin
            if ($urandom_range(0, 299) == 0) begin
                do_reset();
            end else begin
                if ($urandom_range(0, 3) == 0) a = ~a;
                if ($urandom_range(0, 3) == 0) b = ~b;
                step(a, b, $urandom_range(0, 3) != 0);
            end
        end

        step(0, 0, 1);
        step(0, 0, 1);
        for (int i = 0; i < 3; i++)
            check($sformatf("sb_drained[%0d]", i), exp_q[i].size(), 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
